// File: rtl/top_pkg.sv
// Shared types and constants for the top_cpu shift-add multiplier slice.
// Optional build macro used by this slice: TOP_SIGNED_MUL_EN.
package top_pkg;

    localparam int DATA_W    = 8;
    localparam int PROD_W    = 16;
    localparam int MUL_STEPS = 8;
    localparam int CNT_W     = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        MUL    = 3'd3,
        ST_LO  = 3'd4,
        ST_HI  = 3'd5,
        DONE   = 3'd6
    } state_t;

endpackage

// File: rtl/data_mem.sv
// Single-port byte RAM: combinational read, synchronous write, no reset
// so that preloaded contents survive a reset of the surrounding logic.
module data_mem #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] my_memory [0:(1<<ADDR_W)-1];

    assign o_rdata = my_memory[i_addr];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            my_memory[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/top_cpu.sv
// Self-contained compute top: loads two bytes, shift-add multiplies them and
// stores the 16-bit product. TOP_SIGNED_MUL_EN selects two's-complement operands.
module top_cpu
    import top_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int SRC_A  = 0,
    parameter int SRC_B  = 1,
    parameter int DST    = 2
) (
    input  logic clk,
    input  logic reset,
    output logic done
);

    // Truncation to ADDR_W makes DST+1 wrap around the memory.
    localparam logic [ADDR_W-1:0] L_SRC_A  = ADDR_W'(SRC_A);
    localparam logic [ADDR_W-1:0] L_SRC_B  = ADDR_W'(SRC_B);
    localparam logic [ADDR_W-1:0] L_DST_LO = ADDR_W'(DST);
    localparam logic [ADDR_W-1:0] L_DST_HI = ADDR_W'(DST + 1);
    localparam logic [CNT_W-1:0]  L_LAST   = CNT_W'(MUL_STEPS - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [PROD_W-1:0]   r_acc;
    logic [PROD_W-1:0]   r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_done;

    logic [ADDR_W-1:0]   w_addr;
    logic                w_we;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_rdata;
    logic [PROD_W-1:0]   w_mcand_ext;

    data_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dm1 (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

`ifdef TOP_SIGNED_MUL_EN
    assign w_mcand_ext = {{(PROD_W-DATA_W){w_rdata[DATA_W-1]}}, w_rdata};
`else
    assign w_mcand_ext = {{(PROD_W-DATA_W){1'b0}}, w_rdata};
`endif

    assign done = r_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_addr       = L_SRC_A;
        w_we         = 1'b0;
        w_wdata      = r_acc[DATA_W-1:0];
        case (r_state)
            IDLE:   w_next_state = LOAD_A;
            LOAD_A: w_next_state = LOAD_B;
            LOAD_B: begin
                w_addr       = L_SRC_B;
                w_next_state = MUL;
            end
            MUL: begin
                if (r_cnt == L_LAST) begin
                    w_next_state = ST_LO;
                end
            end
            ST_LO: begin
                w_addr       = L_DST_LO;
                w_we         = 1'b1;
                w_wdata      = r_acc[DATA_W-1:0];
                w_next_state = ST_HI;
            end
            ST_HI: begin
                w_addr       = L_DST_HI;
                w_we         = 1'b1;
                w_wdata      = r_acc[PROD_W-1:DATA_W];
                w_next_state = DONE;
            end
            DONE:    w_next_state = DONE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                LOAD_A: begin
                    r_mcand <= w_mcand_ext;
                    r_acc   <= '0;
                end
                LOAD_B: begin
                    r_mplier <= w_rdata;
                    r_cnt    <= '0;
                end
                MUL: begin
                    if (r_mplier[0]) begin
`ifdef TOP_SIGNED_MUL_EN
                        // Multiplier MSB carries weight -128 in two's complement.
                        if (r_cnt == L_LAST) begin
                            r_acc <= r_acc - r_mcand;
                        end else begin
                            r_acc <= r_acc + r_mcand;
                        end
`else
                        r_acc <= r_acc + r_mcand;
`endif
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                end
                ST_HI:   r_done <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_top_cpu.sv
// Directed bench for top_cpu: table of operand/product vectors plus
// hand-written sequences for mid-run reset and post-done stability.
module tb_top_cpu;
    import top_pkg::*;

    logic clk;
    logic reset;
    logic done;

    int checks;
    int errors;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
    } vec_t;

    vec_t vecs [7];

    top_cpu dut (
        .clk   (clk),
        .reset (reset),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] fill_pat(input int i);
        logic [7:0] v;
        v = 8'(i) ^ 8'h5A;
        return v;
    endfunction

    task automatic preload(input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < 256; i++) begin
            dut.dm1.my_memory[i] = fill_pat(i);
        end
        dut.dm1.my_memory[0] = a;
        dut.dm1.my_memory[1] = b;
    endtask

    // Counts rising edges until done is seen; -1 on timeout.
    task automatic run_to_done(output int edges);
        edges = -1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                edges = e;
                break;
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_done"},   int'(done),           0);
        check({tag, "_state"},  int'(dut.r_state),    int'(IDLE));
        check({tag, "_acc"},    int'(dut.r_acc),      0);
        check({tag, "_mcand"},  int'(dut.r_mcand),    0);
        check({tag, "_mplier"}, int'(dut.r_mplier),   0);
        check({tag, "_cnt"},    int'(dut.r_cnt),      0);
    endtask

    task automatic check_result(input string tag, input logic [15:0] prod);
        check({tag, "_lo"},  int'(dut.dm1.my_memory[2]),   int'(prod[7:0]));
        check({tag, "_hi"},  int'(dut.dm1.my_memory[3]),   int'(prod[15:8]));
        check({tag, "_m4"},  int'(dut.dm1.my_memory[4]),   int'(fill_pat(4)));
        check({tag, "_m255"}, int'(dut.dm1.my_memory[255]), int'(fill_pat(255)));
    endtask

    initial begin
        int edges;
        logic [7:0] snap [8];
        checks = 0;
        errors = 0;

        vecs[0] = '{a: 8'h3F, b: 8'h3F, prod: 16'h0F81};
        vecs[1] = '{a: 8'h00, b: 8'hA5, prod: 16'h0000};
        vecs[2] = '{a: 8'h10, b: 8'h02, prod: 16'h0020};
        vecs[3] = '{a: 8'h80, b: 8'h80, prod: 16'h4000};
`ifdef TOP_SIGNED_MUL_EN
        vecs[4] = '{a: 8'hFF, b: 8'hFF, prod: 16'h0001};
        vecs[5] = '{a: 8'hFF, b: 8'h02, prod: 16'hFFFE};
        vecs[6] = '{a: 8'h7F, b: 8'h81, prod: 16'hC0FF};
`else
        vecs[4] = '{a: 8'hFF, b: 8'hFF, prod: 16'hFE01};
        vecs[5] = '{a: 8'hFF, b: 8'h02, prod: 16'h01FE};
        vecs[6] = '{a: 8'h7F, b: 8'h81, prod: 16'h3FFF};
`endif

        // First run: release at 20 ns, done expected by 150 ns.
        reset = 1'b1;
        #2;
        reset = 1'b0;
        preload(8'h3F, 8'h3F);
        #1;
        check_reset_state("por");
        #17;
        reset = 1'b1;
        run_to_done(edges);
        check("first_latency", edges, 13);
        check("first_by_150ns", int'($time <= 150), 1);
        check_result("first", 16'h0F81);

        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            reset = 1'b0;
            #1;
            check_reset_state($sformatf("v%0d_rst", v));
            preload(vecs[v].a, vecs[v].b);
            @(negedge clk);
            reset = 1'b1;
            run_to_done(edges);
            check($sformatf("v%0d_latency", v), edges, 13);
            check_result($sformatf("v%0d", v), vecs[v].prod);
        end

        // Reset during MUL, change operands while held, then rerun.
        @(negedge clk);
        reset = 1'b0;
        preload(8'h3F, 8'h3F);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("mid_state_mul", int'(dut.r_state), int'(MUL));
        check("mid_done_low", int'(done), 0);
        #1;
        reset = 1'b0;
        #1;
        check("mid_async_idle", int'(dut.r_state), int'(IDLE));
        check("mid_async_done", int'(done), 0);
        @(negedge clk);
        @(negedge clk);
        check("mid_hold_done", int'(done), 0);
        dut.dm1.my_memory[0] = 8'h10;
        dut.dm1.my_memory[1] = 8'h02;
        reset = 1'b1;
        run_to_done(edges);
        check("mid_latency", edges, 13);
        check_result("mid", 16'h0020);

        // Post-done: done sticky, memory frozen.
        for (int i = 0; i < 8; i++) begin
            snap[i] = dut.dm1.my_memory[i];
        end
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            check("post_done_sticky", int'(done), 1);
        end
        for (int i = 0; i < 8; i++) begin
            check($sformatf("post_mem%0d", i), int'(dut.dm1.my_memory[i]), int'(snap[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/top_cpu.md
Name: top_cpu

Overview:
- Self-contained compute top: on reset release, reads two 8-bit operands from its internal data memory, multiplies them with a shift-add sequencer, writes the 16-bit product back to memory, then raises done.
- Only ports are clock, reset and done. Operands are preloaded, and results read back, by the bench through the memory array hierarchically (instance dm1, array my_memory).
- Sits as the simulation top under the bench.

Parameters:
- ADDR_W, 8, data-memory address width (2^ADDR_W bytes).
- SRC_A, 0, address of multiplicand byte.
- SRC_B, 1, address of multiplier byte.
- DST, 2, address of product low byte; high byte goes to DST+1.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = held in reset).
- done  output  1  high when product stored; sticky until reset.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset value of all control state:
  - FSM = IDLE, done = 0.
  - Accumulator, multiplicand and multiplier registers = 0.
  - Bit counter = 0.
- Reset never clears data memory, so bench preloads survive reset.
- Data memory:
  - 2^ADDR_W x 8.
  - Combinational read.
  - Synchronous write on rising clk when we = 1.
  - Instance name dm1, array name my_memory.
- FSM, one state per cycle unless noted:
  - IDLE: first edge after reset release -> LOAD_A.
  - LOAD_A: mcand <= {8'b0, mem[SRC_A]} (16-bit), acc <= 0 -> LOAD_B.
  - LOAD_B: mplier <= mem[SRC_B], cnt <= 0 -> MUL.
  - MUL, 8 cycles:
    - if mplier[0], acc <= acc + mcand (16-bit, modulo 2^16).
    - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
    - exit to ST_LO after cnt = 7.
  - ST_LO: mem[DST] <= acc[7:0] -> ST_HI.
  - ST_HI: mem[DST+1] <= acc[15:8] -> DONE.
  - DONE: done = 1 (registered); remain forever; no further memory writes.
- Latency: done rises on the 13th rising edge after reset deassertion (IDLE 1 + loads 2 + MUL 8 + stores 2), i.e. 130 ns at a 10 ns clock.
- Operand cases:
  - Zero operand: product 0x0000 is still written and done still asserts.
  - Full range: 0xFF*0xFF = 0xFE01, no overflow.
- Reset asserted mid-operation:
  - FSM returns to IDLE immediately, done drops.
  - Any bytes already written stay in memory.
  - After release, the sequence restarts from LOAD_A with current memory contents.
- Address arithmetic DST+1 wraps modulo 2^ADDR_W.
- SRC_x may equal DST; operands are latched before any store, so this is safe.

Optional Feature:
- Macro TOP_SIGNED_MUL_EN.
- Defined:
  - Operands are two's-complement signed.
  - LOAD_A sign-extends mem[SRC_A] to 16 bits.
  - Multiplier bit 7 has weight −128: in the final MUL iteration (cnt = 7), subtract mcand instead of adding.
  - Result is the signed 16-bit product, e.g. 0xFF*0x02 -> 0xFFFE.
- Undefined: unsigned behaviour above, e.g. 0xFF*0x02 -> 0x01FE.
- Cycle timing is identical in both builds.

Decomposition:
- Package top_pkg:
  - state enum (IDLE, LOAD_A, LOAD_B, MUL, ST_LO, ST_HI, DONE).
  - DATA_W = 8 and PROD_W = 16 constants.
  - MUL_STEPS = 8.
- One sub-module, data_mem:
  - single-port byte RAM, combinational read, synchronous write.
  - instantiated as dm1 with array my_memory.
  - no reset.
- FSM and datapath stay in top_cpu.

Test Plan:
- Preload mem[0] = 0x3F, mem[1] = 0x3F, release reset at 20 ns -> done = 1 by 150 ns; mem[2] = 0x81, mem[3] = 0x0F.
- mem[0] = 0xFF, mem[1] = 0xFF -> mem[2] = 0x01, mem[3] = 0xFE; done on the 13th edge exactly, never earlier.
- mem[0] = 0x00, mem[1] = 0xA5 -> mem[2] = mem[3] = 0x00, done asserts; mem[4..] unchanged.
- Assert reset during MUL (edge 6), hold 2 cycles, change mem[1] to 0x02 with mem[0] = 0x10, release -> done drops during reset; after 13 edges mem[2] = 0x20, mem[3] = 0x00.
- After done, run 100 further cycles -> done stays 1, memory unchanged.
- With TOP_SIGNED_MUL_EN: mem[0] = 0xFF, mem[1] = 0x02 -> mem[2] = 0xFE, mem[3] = 0xFF; mem[0] = 0x80, mem[1] = 0x80 -> 0x4000.
